// File: rtl/seizure_decision.sv
// ----------------------------------------------------------------------------
// seizure_decision
//
// Purpose:
//    Turns the per-epoch weighted sum (signed, scaled by 2^10) into a stable
//    seizure alarm. Each accepted epoch is classified against THRESHOLD. A run
//    of ONSET_COUNT consecutive positive epochs raises the alarm. A run of
//    HOLD_COUNT consecutive negative epochs drops it again. Cycles without
//    sum_valid are bubbles: they change no state and do not break a run.
//
// Ports:
//    clk            in   system clock, rising edge
//    rst            in   asynchronous, active-high reset
//    sum_in         in   signed weighted sum for the current epoch (WIDTH bits)
//    sum_valid      in   sum_in carries an epoch this cycle
//    clear          in   synchronous soft clear; overrides sum_valid
//    epoch_pos      out  class of the last accepted epoch (1 = positive)
//    decision_valid out  one-cycle pulse, one cycle after each accepted epoch
//    alarm          out  debounced alarm level
//    alarm_start    out  one-cycle pulse when the alarm rises
//    pos_count      out  consecutive-positive progress while arming
//    event_count    out  number of alarm onsets, saturating (EVT_W bits)
//
// All outputs are registered. An epoch's effect appears one cycle after
// its sum_valid cycle.
// ----------------------------------------------------------------------------
module seizure_decision #(
   parameter int WIDTH       = 12,
   parameter int THRESHOLD   = 512,
   parameter int ONSET_COUNT = 3,
   parameter int HOLD_COUNT  = 8,
   parameter int EVT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sum_in,
   input  logic             sum_valid,
   input  logic             clear,
   output logic             epoch_pos,
   output logic             decision_valid,
   output logic             alarm,
   output logic             alarm_start,
   output logic [3:0]       pos_count,
   output logic [EVT_W-1:0] event_count
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ARMING = 2'd1,
      S_ALARM  = 2'd2
   } state_t;

   // Constants are resized once so the datapath compares equal widths.
   localparam logic signed [WIDTH-1:0] THRESH_C  = WIDTH'(THRESHOLD);
   localparam logic [3:0]              ONSET_C   = 4'(ONSET_COUNT);
   localparam logic [3:0]              HOLD_C    = 4'(HOLD_COUNT);
   localparam logic [EVT_W-1:0]        EVT_MAX_C = {EVT_W{1'b1}};
   localparam logic [EVT_W-1:0]        EVT_ONE_C = {{(EVT_W-1){1'b0}}, 1'b1};
   localparam logic [EVT_W-1:0]        EVT_ZERO_C = {EVT_W{1'b0}};

   // Registered state and outputs.
   state_t           state_q,       state_d;
   logic [3:0]       hold_q,        hold_d;
   logic [3:0]       pos_cnt_q,     pos_cnt_d;
   logic [EVT_W-1:0] evt_q,         evt_d;
   logic             epoch_pos_q,   epoch_pos_d;
   logic             dv_q,          dv_d;
   logic             alarm_q,       alarm_d;
   logic             alarm_start_q, alarm_start_d;

   // Epoch classification and onset request.
   logic             pos_s;
   logic             onset_s;
   logic [3:0]       pos_cnt_inc_s;

   // Signed compare: every negative sum falls below a positive threshold.
   assign pos_s = ($signed(sum_in) >= THRESH_C);

   // pos_count never exceeds ONSET_COUNT-1 (<= 14), so the increment cannot wrap.
   assign pos_cnt_inc_s = pos_cnt_q + 4'd1;

   // Next-state logic for the decision FSM, counters and output registers.
   always_comb begin
      state_d       = state_q;
      hold_d        = hold_q;
      pos_cnt_d     = pos_cnt_q;
      evt_d         = evt_q;
      epoch_pos_d   = epoch_pos_q;
      alarm_d       = alarm_q;
      alarm_start_d = 1'b0;
      dv_d          = 1'b0;
      onset_s       = 1'b0;

      if (clear) begin
         // The epoch presented with clear is dropped, so no decision pulse.
         state_d     = S_IDLE;
         hold_d      = 4'd0;
         pos_cnt_d   = 4'd0;
         evt_d       = EVT_ZERO_C;
         epoch_pos_d = 1'b0;
         alarm_d     = 1'b0;
      end else if (sum_valid) begin
         dv_d        = 1'b1;
         epoch_pos_d = pos_s;

         case (state_q)
            S_IDLE: begin
               if (pos_s) begin
                  if (ONSET_C == 4'd1) begin
                     onset_s = 1'b1;
                  end else begin
                     state_d   = S_ARMING;
                     pos_cnt_d = 4'd1;
                  end
               end else begin
                  pos_cnt_d = 4'd0;
               end
            end

            S_ARMING: begin
               if (pos_s) begin
                  if (pos_cnt_inc_s == ONSET_C) begin
                     onset_s = 1'b1;
                  end else begin
                     pos_cnt_d = pos_cnt_inc_s;
                  end
               end else begin
                  // A negative epoch breaks the run; the count is not kept.
                  state_d   = S_IDLE;
                  pos_cnt_d = 4'd0;
               end
            end

            S_ALARM: begin
               if (pos_s) begin
                  // Any positive epoch restarts the offset hold window.
                  hold_d = HOLD_C;
               end else if (hold_q > 4'd1) begin
                  hold_d = hold_q - 4'd1;
               end else begin
                  state_d   = S_IDLE;
                  alarm_d   = 1'b0;
                  hold_d    = 4'd0;
                  pos_cnt_d = 4'd0;
               end
            end

            default: begin
               // Unreachable encoding: recover to a quiet IDLE.
               state_d   = S_IDLE;
               alarm_d   = 1'b0;
               hold_d    = 4'd0;
               pos_cnt_d = 4'd0;
            end
         endcase

         if (onset_s) begin
            state_d       = S_ALARM;
            alarm_d       = 1'b1;
            alarm_start_d = 1'b1;
            hold_d        = HOLD_C;
            pos_cnt_d     = 4'd0;
            // Saturate rather than wrap so the host never sees a false low count.
            if (evt_q != EVT_MAX_C) begin
               evt_d = evt_q + EVT_ONE_C;
            end else begin
               evt_d = evt_q;
            end
         end else begin
            alarm_start_d = 1'b0;
         end
      end else begin
         // Bubble: hold everything; pulses fall back to zero via defaults.
         state_d = state_q;
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         hold_q        <= 4'd0;
         pos_cnt_q     <= 4'd0;
         evt_q         <= EVT_ZERO_C;
         epoch_pos_q   <= 1'b0;
         dv_q          <= 1'b0;
         alarm_q       <= 1'b0;
         alarm_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         hold_q        <= hold_d;
         pos_cnt_q     <= pos_cnt_d;
         evt_q         <= evt_d;
         epoch_pos_q   <= epoch_pos_d;
         dv_q          <= dv_d;
         alarm_q       <= alarm_d;
         alarm_start_q <= alarm_start_d;
      end
   end

   assign epoch_pos      = epoch_pos_q;
   assign decision_valid = dv_q;
   assign alarm          = alarm_q;
   assign alarm_start    = alarm_start_q;
   assign pos_count      = pos_cnt_q;
   assign event_count    = evt_q;

endmodule

// File: tb/tb_seizure_decision.sv
// ----------------------------------------------------------------------------
// tb_seizure_decision
//
// Directed bench for seizure_decision with THRESHOLD=512, ONSET_COUNT=3,
// HOLD_COUNT=4, EVT_W=8. Inputs change on the falling edge; outputs are
// sampled 1 time unit after the rising edge that consumed the step.
// ----------------------------------------------------------------------------
module tb_seizure_decision;

   logic              clk;
   logic              rst;
   logic [11:0]       sum_in;
   logic              sum_valid;
   logic              clear;
   logic              epoch_pos;
   logic              decision_valid;
   logic              alarm;
   logic              alarm_start;
   logic [3:0]        pos_count;
   logic [7:0]        event_count;

   int checks;
   int errors;

   seizure_decision #(
      .WIDTH       (12),
      .THRESHOLD   (512),
      .ONSET_COUNT (3),
      .HOLD_COUNT  (4),
      .EVT_W       (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .sum_in         (sum_in),
      .sum_valid      (sum_valid),
      .clear          (clear),
      .epoch_pos      (epoch_pos),
      .decision_valid (decision_valid),
      .alarm          (alarm),
      .alarm_start    (alarm_start),
      .pos_count      (pos_count),
      .event_count    (event_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic ep, input logic dv, input logic al,
                          input logic as, input logic [3:0] pc, input logic [7:0] ev);
      chk({tag, ".epoch_pos"},      {31'd0, epoch_pos},      {31'd0, ep});
      chk({tag, ".decision_valid"}, {31'd0, decision_valid}, {31'd0, dv});
      chk({tag, ".alarm"},          {31'd0, alarm},          {31'd0, al});
      chk({tag, ".alarm_start"},    {31'd0, alarm_start},    {31'd0, as});
      chk({tag, ".pos_count"},      {28'd0, pos_count},      {28'd0, pc});
      chk({tag, ".event_count"},    {24'd0, event_count},    {24'd0, ev});
   endtask

   // One clock step: drive on the falling edge, sample just after the rising edge.
   task automatic step(input logic v, input logic signed [11:0] s, input logic c);
      @(negedge clk);
      sum_valid = v;
      sum_in    = s;
      clear     = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int hold_seq [7];
      logic hold_exp [7];
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      sum_in    = 12'd0;
      sum_valid = 1'b0;
      clear     = 1'b0;
      hold_seq  = '{100, 100, 600, 100, 100, 100, 100};
      hold_exp  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

      // Power-on reset.
      #12;
      chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
      @(negedge clk);
      rst = 1'b0;

      // Onset on consecutive epochs.
      step(1'b1, 12'sd600, 1'b0);
      chk_all("onset1", 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 8'd0);
      step(1'b1, 12'sd600, 1'b0);
      chk_all("onset2", 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 8'd0);
      step(1'b1, 12'sd600, 1'b0);
      chk_all("onset3", 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 8'd1);
      // Bubble carrying a positive sum must be ignored.
      step(1'b0, 12'sd600, 1'b0);
      chk_all("onset_bubble", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 8'd1);

      // Offset hold with a reload at the third epoch.
      for (int i = 0; i < 7; i++) begin
         step(1'b1, 12'(hold_seq[i]), 1'b0);
         chk($sformatf("hold%0d.alarm", i), {31'd0, alarm}, {31'd0, hold_exp[i]});
      end
      chk("hold_drop.alarm_start", {31'd0, alarm_start}, 32'd0);
      chk("hold_drop.event_count", {24'd0, event_count}, 32'd1);

      // Onset with two bubbles between epochs.
      step(1'b1, 12'sd600, 1'b0);
      step(1'b0, 12'sd100, 1'b0);
      step(1'b0, 12'sd100, 1'b0);
      chk_all("bub_a", 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 8'd1);
      step(1'b1, 12'sd600, 1'b0);
      chk("bub_b.pos_count", {28'd0, pos_count}, 32'd2);
      step(1'b0, 12'sd100, 1'b0);
      step(1'b0, 12'sd100, 1'b0);
      step(1'b1, 12'sd600, 1'b0);
      chk_all("bub_c", 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 8'd2);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 12'sd100, 1'b0);
      end
      chk_all("bub_drop", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd2);

      // Broken run.
      step(1'b1, 12'sd600, 1'b0);
      chk_all("brk1", 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 8'd2);
      step(1'b1, 12'sd600, 1'b0);
      chk_all("brk2", 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 8'd2);
      step(1'b1, 12'sd100, 1'b0);
      chk_all("brk3", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd2);
      step(1'b1, 12'sd600, 1'b0);
      chk_all("brk4", 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 8'd2);
      step(1'b1, 12'sd600, 1'b0);
      chk("brk5.pos_count", {28'd0, pos_count}, 32'd2);

      // Clear while arming, with a valid positive epoch that would complete the run.
      step(1'b1, 12'sd600, 1'b1);
      chk_all("clear", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);

      // Threshold boundary.
      step(1'b1, 12'sd511, 1'b0);
      chk_all("thr511", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
      step(1'b1, 12'sd512, 1'b0);
      chk_all("thr512", 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 8'd0);
      step(1'b1, -12'sd2048, 1'b0);
      chk_all("thrneg", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
      step(1'b1, 12'sd2047, 1'b0);
      chk_all("thrmax", 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 8'd0);

      // Asynchronous reset in the middle of an alarm.
      step(1'b1, 12'sd600, 1'b0);
      step(1'b1, 12'sd600, 1'b0);
      chk_all("pre_rst", 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 8'd1);
      #2;
      rst = 1'b1;
      #1;
      chk_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
      @(negedge clk);
      sum_valid = 1'b0;
      rst       = 1'b0;
      step(1'b1, 12'sd600, 1'b0);
      chk_all("post_rst", 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 8'd0);

      // Event counter saturation.
      step(1'b0, 12'sd0, 1'b1);
      chk("sat_clear.event_count", {24'd0, event_count}, 32'd0);
      for (int n = 0; n < 255; n++) begin
         for (int k = 0; k < 3; k++) step(1'b1, 12'sd600, 1'b0);
         for (int k = 0; k < 4; k++) step(1'b1, 12'sd100, 1'b0);
      end
      chk_all("sat255", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd255);
      for (int k = 0; k < 3; k++) step(1'b1, 12'sd600, 1'b0);
      chk_all("sat256", 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 8'd255);
      step(1'b0, 12'sd0, 1'b0);
      chk_all("sat_hold", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 8'd255);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
